// File: rtl/mem_port_sched_if.sv
// Single 8-bit memory port shared by the core. The scheduler drives it as master;
// the memory system answers as slave with a one-cycle mem_ack per request.
interface mem_port_sched_if #(
   parameter int AW = 16
);
   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_wdata;
   logic [7:0]    mem_rdata;
   logic          mem_ack;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_rdata, mem_ack
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_rdata, mem_ack
   );
endinterface

// File: rtl/mem_port_sched.sv
// Memory port scheduler: arbitrates the single memory port between execute-stage
// accesses and the instruction prefetcher, which fills a rotating byte queue.
module mem_port_sched #(
   parameter int            QDEPTH   = 16,
   parameter int            AW       = 16,
   parameter logic [AW-1:0] RESET_PC = '0
) (
   input  logic                     clk,
   input  logic                     reset,
   mem_port_sched_if.master         mem,
   input  logic                     exe_req,
   input  logic                     exe_we,
   input  logic [AW-1:0]            exe_addr,
   input  logic [7:0]               exe_wdata,
   output logic                     exe_ack,
   output logic [7:0]               exe_rdata,
   input  logic                     br_taken,
   input  logic [AW-1:0]            br_target,
   output logic [7:0]               q_data,
   output logic                     q_valid,
   input  logic                     q_pop,
   output logic [$clog2(QDEPTH):0]  q_count,
   output logic [AW-1:0]            fetch_pc
);

   localparam int PW = $clog2(QDEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] QFULL = CW'(QDEPTH);

   typedef enum logic [1:0] {
      IDLE,
      IFETCH,
      DATA
   } state_t;

   state_t        state;
   logic          flush_pend;
   logic [7:0]    q_mem [QDEPTH];
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic          push;
   logic          pop;

   // A branch in the same cycle wins over both queue operations.
   assign push    = (state == IFETCH) && mem.mem_ack && !flush_pend && !br_taken;
   assign pop     = q_pop && q_valid && !br_taken;
   assign q_valid = (q_count != '0);
   assign q_data  = q_valid ? q_mem[head] : 8'h00;

   always_ff @(posedge clk) begin
      if (push) begin
         q_mem[tail] <= mem.mem_rdata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || br_taken) begin
         head    <= '0;
         tail    <= '0;
         q_count <= '0;
      end else begin
         if (push) begin
            tail <= tail + 1'b1;
         end
         if (pop) begin
            head <= head + 1'b1;
         end
         if (push && !pop) begin
            q_count <= q_count + 1'b1;
         end else if (pop && !push) begin
            q_count <= q_count - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         flush_pend    <= 1'b0;
         mem.mem_req   <= 1'b0;
         mem.mem_we    <= 1'b0;
         mem.mem_addr  <= '0;
         mem.mem_wdata <= 8'h00;
         exe_ack       <= 1'b0;
         exe_rdata     <= 8'h00;
         fetch_pc      <= RESET_PC;
      end else begin
         exe_ack <= 1'b0;

         if (br_taken) begin
            fetch_pc <= br_target;
         end else if (push) begin
            fetch_pc <= fetch_pc + 1'b1;
         end

         case (state)
            // exe_req seen alongside exe_ack belongs to the access just completed.
            IDLE: begin
               if (exe_req && !exe_ack) begin
                  state         <= DATA;
                  mem.mem_req   <= 1'b1;
                  mem.mem_we    <= exe_we;
                  mem.mem_addr  <= exe_addr;
                  mem.mem_wdata <= exe_wdata;
               end else if (q_count < QFULL) begin
                  state        <= IFETCH;
                  mem.mem_req  <= 1'b1;
                  mem.mem_we   <= 1'b0;
                  mem.mem_addr <= br_taken ? br_target : fetch_pc;
               end
            end

            IFETCH: begin
               if (mem.mem_ack) begin
                  state       <= IDLE;
                  mem.mem_req <= 1'b0;
                  flush_pend  <= 1'b0;
               end else if (br_taken) begin
                  flush_pend <= 1'b1;
               end
            end

            DATA: begin
               if (mem.mem_ack) begin
                  state       <= IDLE;
                  mem.mem_req <= 1'b0;
                  exe_ack     <= 1'b1;
                  exe_rdata   <= mem.mem_rdata;
               end
            end

            default: begin
               state       <= IDLE;
               mem.mem_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_sched.sv
// Bench for mem_port_sched: a transaction-level model (byte queue, fetch PC,
// one outstanding access) checks the DUT each cycle under table, directed and random stimulus.
module tb_mem_port_sched;

   localparam int          QDEPTH   = 16;
   localparam logic [15:0] RESET_PC = 16'h0200;

   typedef enum int {K_NONE, K_FETCH, K_DATA} kind_t;

   typedef struct {
      string       name;
      bit          do_reset;
      bit          do_branch;
      logic [15:0] target;
      int          ack_delay;
      int          pops;
      int          cycles;
      int          exp_count;
      logic [15:0] exp_pc;
      bit          exp_req;
   } vec_t;

   logic        clk;
   logic        reset;
   logic        exe_req;
   logic        exe_we;
   logic [15:0] exe_addr;
   logic [7:0]  exe_wdata;
   logic        exe_ack;
   logic [7:0]  exe_rdata;
   logic        br_taken;
   logic [15:0] br_target;
   logic [7:0]  q_data;
   logic        q_valid;
   logic        q_pop;
   logic [4:0]  q_count;
   logic [15:0] fetch_pc;

   mem_port_sched_if #(.AW(16)) mif ();

   mem_port_sched #(
      .QDEPTH   (QDEPTH),
      .AW       (16),
      .RESET_PC (RESET_PC)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .mem       (mif),
      .exe_req   (exe_req),
      .exe_we    (exe_we),
      .exe_addr  (exe_addr),
      .exe_wdata (exe_wdata),
      .exe_ack   (exe_ack),
      .exe_rdata (exe_rdata),
      .br_taken  (br_taken),
      .br_target (br_target),
      .q_data    (q_data),
      .q_valid   (q_valid),
      .q_pop     (q_pop),
      .q_count   (q_count),
      .fetch_pc  (fetch_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // Reference model state
   logic [7:0]  mq [$];
   logic [15:0] model_pc;
   kind_t       inflight;
   kind_t       last_kind;
   logic [15:0] inflight_addr;
   bit          drop_flag;
   bit          exe_pending;
   int          idle_run;
   int          issue_count;

   // Memory responder state
   int ack_delay;
   int req_age;

   // Inputs applied at the edge being modelled
   bit          a_pop;
   bit          a_br;
   logic [15:0] a_tgt;
   bit          a_ack;
   bit          a_exe_req;
   bit          a_exe_we;
   logic [15:0] a_exe_addr;
   logic [7:0]  a_exe_wdata;
   int          prev_size;

   function automatic logic [7:0] mem_byte(input logic [15:0] a);
      return a[7:0] ^ a[15:8] ^ 8'hA5;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic respond();
      if (mif.mem_ack) begin
         mif.mem_ack   = 1'b0;
         mif.mem_rdata = 8'($urandom);
         req_age       = 0;
      end else if (mif.mem_req) begin
         if (req_age >= ack_delay) begin
            mif.mem_ack   = 1'b1;
            mif.mem_rdata = mem_byte(mif.mem_addr);
            req_age       = 0;
         end else begin
            req_age++;
         end
      end
   endtask

   task automatic model_step();
      bit         acked_now = 0;
      bit         data_done = 0;
      bit         do_push = 0;
      logic [7:0] fb = 8'h00;

      if (a_ack && inflight == K_FETCH) begin
         acked_now = 1;
         do_push   = !drop_flag && !a_br;
         fb        = mem_byte(inflight_addr);
         drop_flag = 0;
         inflight  = K_NONE;
      end else if (a_ack && inflight == K_DATA) begin
         acked_now = 1;
         data_done = 1;
         inflight  = K_NONE;
      end

      if (a_br) begin
         mq.delete();
         model_pc = a_tgt;
         if (inflight == K_FETCH) drop_flag = 1;
      end else begin
         if (a_pop && mq.size() > 0) mq.delete(0);
         if (do_push) begin
            mq.push_back(fb);
            model_pc = model_pc + 16'd1;
         end
      end

      checkOutput("q_count", 32'(q_count), 32'(mq.size()));
      checkOutput("q_valid", 32'(q_valid), 32'(mq.size() > 0));
      if (mq.size() > 0) checkOutput("q_data", 32'(q_data), 32'(mq[0]));
      checkOutput("fetch_pc", 32'(fetch_pc), 32'(model_pc));
      checkOutput("exe_ack", 32'(exe_ack), 32'(data_done));
      if (data_done) checkOutput("exe_rdata", 32'(exe_rdata), 32'(mem_byte(inflight_addr)));

      if (acked_now) begin
         checkOutput("req_drop", 32'(mif.mem_req), 32'd0);
      end else if (inflight != K_NONE) begin
         checkOutput("req_hold", 32'(mif.mem_req), 32'd1);
      end else if (mif.mem_req) begin
         issue_count++;
         if (a_exe_req) begin
            checkOutput("data_we", 32'(mif.mem_we), 32'(a_exe_we));
            checkOutput("data_addr", 32'(mif.mem_addr), 32'(a_exe_addr));
            if (a_exe_we) checkOutput("data_wdata", 32'(mif.mem_wdata), 32'(a_exe_wdata));
            inflight      = K_DATA;
            inflight_addr = a_exe_addr;
         end else begin
            checkOutput("fetch_we", 32'(mif.mem_we), 32'd0);
            checkOutput("fetch_addr", 32'(mif.mem_addr), 32'(model_pc));
            checkOutput("fetch_room", 32'(prev_size < QDEPTH), 32'd1);
            inflight      = K_FETCH;
            inflight_addr = model_pc;
         end
         last_kind = inflight;
      end

      if (inflight == K_NONE && !mif.mem_req && (exe_pending || mq.size() < QDEPTH))
         idle_run++;
      else
         idle_run = 0;
      checkOutput("no_stall", 32'(idle_run > 3), 32'd0);
   endtask

   task automatic applyStimulus(input bit pop, input bit br, input logic [15:0] tgt);
      q_pop       = pop;
      br_taken    = br;
      br_target   = tgt;
      a_pop       = pop;
      a_br        = br;
      a_tgt       = tgt;
      a_ack       = mif.mem_ack;
      a_exe_req   = exe_req;
      a_exe_we    = exe_we;
      a_exe_addr  = exe_addr;
      a_exe_wdata = exe_wdata;
      prev_size   = mq.size();
      @(posedge clk);
      #1;
      q_pop    = 1'b0;
      br_taken = 1'b0;
      model_step();
      respond();
      if (exe_ack) begin
         exe_req     = 1'b0;
         exe_pending = 0;
      end
   endtask

   task automatic start_exe(input bit we, input logic [15:0] addr, input logic [7:0] wdata);
      exe_req     = 1'b1;
      exe_we      = we;
      exe_addr    = addr;
      exe_wdata   = wdata;
      exe_pending = 1;
   endtask

   task automatic do_reset();
      reset       = 1'b1;
      q_pop       = 1'b0;
      br_taken    = 1'b0;
      exe_req     = 1'b0;
      exe_pending = 0;
      mif.mem_ack = 1'b0;
      req_age     = 0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_q_count", 32'(q_count), 32'd0);
      checkOutput("rst_q_valid", 32'(q_valid), 32'd0);
      checkOutput("rst_q_data", 32'(q_data), 32'd0);
      checkOutput("rst_fetch_pc", 32'(fetch_pc), 32'(RESET_PC));
      checkOutput("rst_mem_req", 32'(mif.mem_req), 32'd0);
      checkOutput("rst_mem_we", 32'(mif.mem_we), 32'd0);
      checkOutput("rst_mem_addr", 32'(mif.mem_addr), 32'd0);
      checkOutput("rst_exe_ack", 32'(exe_ack), 32'd0);
      checkOutput("rst_exe_rdata", 32'(exe_rdata), 32'd0);
      reset     = 1'b0;
      mq.delete();
      model_pc  = RESET_PC;
      inflight  = K_NONE;
      drop_flag = 0;
      idle_run  = 0;
   endtask

   task automatic add_vec(input string name, input bit rst, input bit br, input logic [15:0] tgt,
                          input int dly, input int pops, input int cyc, input int cnt,
                          input logic [15:0] pc, input bit req, inout vec_t vq [$]);
      vec_t v;
      v.name = name; v.do_reset = rst; v.do_branch = br; v.target = tgt;
      v.ack_delay = dly; v.pops = pops; v.cycles = cyc; v.exp_count = cnt;
      v.exp_pc = pc; v.exp_req = req;
      vq.push_back(v);
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog expired at %0t", $time);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      vec_t vq [$];
      vec_t v;
      int   n;
      int   mark;

      reset = 1'b1; q_pop = 1'b0; br_taken = 1'b0; br_target = 16'h0;
      exe_req = 1'b0; exe_we = 1'b0; exe_addr = 16'h0; exe_wdata = 8'h0;
      mif.mem_ack = 1'b0; mif.mem_rdata = 8'h00;
      ack_delay = 1; req_age = 0; issue_count = 0; last_kind = K_NONE;
      mq.delete(); model_pc = RESET_PC; inflight = K_NONE; drop_flag = 0;
      exe_pending = 0; idle_run = 0;

      add_vec("fill_0200", 1, 0, 16'h0000, 1, 0, 80, 16, 16'h0210, 0, vq);
      add_vec("pop3_refill", 0, 0, 16'h0000, 1, 3, 40, 16, 16'h0213, 0, vq);
      add_vec("br_fff8_wrap", 0, 1, 16'hFFF8, 0, 0, 60, 16, 16'h0008, 0, vq);
      add_vec("br_fff0_to_0", 0, 1, 16'hFFF0, 1, 0, 70, 16, 16'h0000, 0, vq);
      add_vec("pop5_slow_mem", 0, 0, 16'h0000, 2, 5, 60, 16, 16'h0005, 0, vq);

      foreach (vq[i]) begin
         v = vq[i];
         if (v.do_reset) do_reset();
         ack_delay = v.ack_delay;
         if (v.do_branch) applyStimulus(0, 1, v.target);
         for (int c = 0; c < v.cycles; c++) applyStimulus(c < v.pops, 0, 16'h0000);
         checkOutput({v.name, "_count"}, 32'(q_count), 32'(v.exp_count));
         checkOutput({v.name, "_pc"}, 32'(fetch_pc), 32'(v.exp_pc));
         checkOutput({v.name, "_req"}, 32'(mif.mem_req), 32'(v.exp_req));
      end

      // Execute read wins over the prefetch that the pop makes pending
      mark = issue_count;
      start_exe(0, 16'h00FE, 8'h00);
      applyStimulus(1, 0, 16'h0000);
      n = 0;
      while (!exe_ack && n < 20) begin applyStimulus(0, 0, 16'h0000); n++; end
      checkOutput("t3_exe_ack_seen", 32'(exe_ack), 32'd1);
      checkOutput("t3_exe_rdata", 32'(exe_rdata), 32'(mem_byte(16'h00FE)));
      checkOutput("t3_one_issue", 32'(issue_count - mark), 32'd1);
      checkOutput("t3_data_first", 32'(last_kind == K_DATA), 32'd1);
      n = 0;
      while (!(q_count == 5'd16 && !mif.mem_req) && n < 40) begin applyStimulus(0, 0, 16'h0000); n++; end
      checkOutput("t3_refill_pc", 32'(fetch_pc), 32'h0006);

      // Branch while a slow prefetch is in flight
      ack_delay = 3;
      applyStimulus(1, 0, 16'h0000);
      n = 0;
      while (!mif.mem_req && n < 10) begin applyStimulus(0, 0, 16'h0000); n++; end
      checkOutput("t4_req_seen", 32'(mif.mem_req), 32'd1);
      applyStimulus(0, 1, 16'h8000);
      checkOutput("t4_flush_count", 32'(q_count), 32'd0);
      checkOutput("t4_flush_pc", 32'(fetch_pc), 32'h8000);
      n = 0;
      while (!q_valid && n < 40) begin applyStimulus(0, 0, 16'h0000); n++; end
      checkOutput("t4_first_byte", 32'(q_data), 32'(mem_byte(16'h8000)));
      checkOutput("t4_first_count", 32'(q_count), 32'd1);
      checkOutput("t4_first_pc", 32'(fetch_pc), 32'h8001);

      // Push and pop on the same edge at five queued bytes
      ack_delay = 0;
      n = 0;
      while (!(q_count == 5'd5 && mif.mem_ack) && n < 60) begin applyStimulus(0, 0, 16'h0000); n++; end
      checkOutput("t6_setup", 32'(q_count == 5'd5 && mif.mem_ack), 32'd1);
      applyStimulus(1, 0, 16'h0000);
      checkOutput("t6_count_kept", 32'(q_count), 32'd5);
      checkOutput("t6_head_next", 32'(q_data), 32'(mem_byte(16'h8001)));

      // Reset abandons an in-flight fetch; a stray ack afterwards is ignored
      ack_delay = 3;
      n = 0;
      while (!(mif.mem_req && !mif.mem_ack) && n < 20) begin applyStimulus(0, 0, 16'h0000); n++; end
      do_reset();
      mif.mem_ack   = 1'b1;
      mif.mem_rdata = 8'hEE;
      applyStimulus(0, 0, 16'h0000);
      checkOutput("stray_ack_count", 32'(q_count), 32'd0);
      checkOutput("stray_ack_pc", 32'(fetch_pc), 32'(RESET_PC));

      // Randomized traffic against the model
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         logic [15:0] tgt;
         bit          br;
         if (c % 64 == 0) ack_delay = $urandom_range(0, 3);
         if (!exe_pending && !exe_ack && $urandom_range(0, 19) == 0)
            start_exe(1'($urandom), 16'($urandom), 8'($urandom));
         br  = ($urandom_range(0, 29) == 0);
         tgt = ($urandom_range(0, 3) == 0) ? (16'hFFF0 | 16'($urandom_range(0, 15))) : 16'($urandom);
         applyStimulus(1'($urandom), br, tgt);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
